// File: rtl/alu_if.sv
// Operand/opcode and result/flag bundle for the registered ALU.
// The master drives the operation; the slave (the ALU) returns the registered result.
interface alu_if;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] Sel;
    logic [7:0] Out;
    logic [3:0] Flag;

    modport master (
        output A,
        output B,
        output Sel,
        input  Out,
        input  Flag
    );

    modport slave (
        input  A,
        input  B,
        input  Sel,
        output Out,
        output Flag
    );
endinterface

// File: rtl/alu.sv
// 8-bit registered ALU: combinational op decode into a single output register stage.
// Flag = {V, N, Z, C}; Z and N always follow the result, C/V depend on the op.
module alu (
    input  logic   clk,
    input  logic   rst_n,
    alu_if.slave   bus
);
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_XNOR = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_ROL  = 4'hC;
    localparam logic [3:0] OP_ROR  = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    logic [7:0]  r_out;
    logic [3:0]  r_flag;

    logic [8:0]  w_sum;
    logic [7:0]  w_diff;
    logic [15:0] w_prod;
    logic [7:0]  w_quot;
    logic        w_shift_ok;
    logic [15:0] w_shl;
    logic [15:0] w_shr;
    logic [7:0]  w_res;
    logic        w_c;
    logic        w_v;

    assign w_sum      = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_diff     = bus.A - bus.B;
    assign w_prod     = 16'(bus.A) * 16'(bus.B);
    assign w_quot     = (bus.B == 8'h00) ? 8'hFF : (bus.A / bus.B);
    assign w_shift_ok = (bus.B <= 8'd8);

    // Widened shifts leave the last bit shifted out at bit 8 (left) or bit 7 (right);
    // a zero shift amount naturally yields a zero carry.
    assign w_shl = w_shift_ok ? ({8'h00, bus.A} << bus.B[3:0]) : 16'h0000;
    assign w_shr = w_shift_ok ? ({bus.A, 8'h00} >> bus.B[3:0]) : 16'h0000;

    always_comb begin
        w_res = 8'h00;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.Sel)
            OP_ADD: begin
                w_res = w_sum[7:0];
                w_c   = w_sum[8];
                w_v   = (bus.A[7] == bus.B[7]) && (w_sum[7] != bus.A[7]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_c   = (bus.A < bus.B);
                w_v   = (bus.A[7] != bus.B[7]) && (w_diff[7] != bus.A[7]);
            end
            OP_MUL: begin
                w_res = w_prod[7:0];
                w_c   = |w_prod[15:8];
                w_v   = |w_prod[15:8];
            end
            OP_DIV: begin
                w_res = w_quot;
                w_v   = (bus.B == 8'h00);
            end
            OP_SHL: begin
                w_res = w_shl[7:0];
                w_c   = w_shl[8];
            end
            OP_SHR: begin
                w_res = w_shr[15:8];
                w_c   = w_shr[7];
            end
            OP_AND:  w_res = bus.A & bus.B;
            OP_OR:   w_res = bus.A | bus.B;
            OP_XOR:  w_res = bus.A ^ bus.B;
            OP_XNOR: w_res = ~(bus.A ^ bus.B);
            OP_NAND: w_res = ~(bus.A & bus.B);
            OP_NOR:  w_res = ~(bus.A | bus.B);
            OP_ROL: begin
                w_res = {bus.A[6:0], bus.A[7]};
                w_c   = bus.A[7];
            end
            OP_ROR: begin
                w_res = {bus.A[0], bus.A[7:1]};
                w_c   = bus.A[0];
            end
            OP_GT:   w_res = (bus.A > bus.B) ? 8'h01 : 8'h00;
            OP_EQ:   w_res = (bus.A == bus.B) ? 8'h01 : 8'h00;
            default: w_res = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= 8'h00;
            r_flag <= 4'h0;
        end else begin
            r_out  <= w_res;
            r_flag <= {w_v, w_res[7], (w_res == 8'h00), w_c};
        end
    end

    assign bus.Out  = r_out;
    assign bus.Flag = r_flag;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU, including asynchronous reset behaviour.
module tb_alu;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_if u_if ();

    alu u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got Out/Flag=%h/%b expected %h/%b",
                     tag, got[11:4], got[3:0], exp[11:4], exp[3:0]);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] sel, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_out,
                          input logic [3:0] exp_flag);
        @(negedge clk);
        u_if.Sel = sel;
        u_if.A   = a;
        u_if.B   = b;
        @(posedge clk);
        #1;
        check_eq(tag, {u_if.Out, u_if.Flag}, {exp_out, exp_flag});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        u_if.Sel = 4'h0;
        u_if.A   = 8'h12;
        u_if.B   = 8'h34;
        #1;
        check_eq("reset_init", {u_if.Out, u_if.Flag}, 12'h000);
        @(posedge clk);
        #1;
        check_eq("reset_held", {u_if.Out, u_if.Flag}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_c1_0f",  4'h0, 8'hC1, 8'h0F, 8'hD0, 4'b0100);
        run_op("add_ff_ff",  4'h0, 8'hFF, 8'hFF, 8'hFE, 4'b0101);
        run_op("add_7f_01",  4'h0, 8'h7F, 8'h01, 8'h80, 4'b1100);
        run_op("add_80_80",  4'h0, 8'h80, 8'h80, 8'h00, 4'b1011);
        run_op("sub_c1_0f",  4'h1, 8'hC1, 8'h0F, 8'hB2, 4'b0100);
        run_op("sub_0f_c1",  4'h1, 8'h0F, 8'hC1, 8'h4E, 4'b0001);
        run_op("sub_80_01",  4'h1, 8'h80, 8'h01, 8'h7F, 4'b1000);
        run_op("mul_1f_1f",  4'h2, 8'h1F, 8'h1F, 8'hC1, 4'b1101);
        run_op("mul_02_03",  4'h2, 8'h02, 8'h03, 8'h06, 4'b0000);
        run_op("div_c1_0f",  4'h3, 8'hC1, 8'h0F, 8'h0C, 4'b0000);
        run_op("div_0f_c1",  4'h3, 8'h0F, 8'hC1, 8'h00, 4'b0010);
        run_op("div_by_0",   4'h3, 8'hC1, 8'h00, 8'hFF, 4'b1100);
        run_op("shl_ff_4",   4'h4, 8'hFF, 8'h04, 8'hF0, 4'b0101);
        run_op("shr_ff_4",   4'h5, 8'hFF, 8'h04, 8'h0F, 4'b0001);
        run_op("shl_ff_2",   4'h4, 8'hFF, 8'h02, 8'hFC, 4'b0101);
        run_op("shl_ff_9",   4'h4, 8'hFF, 8'h09, 8'h00, 4'b0010);
        run_op("shr_ff_9",   4'h5, 8'hFF, 8'h09, 8'h00, 4'b0010);
        run_op("shl_81_8",   4'h4, 8'h81, 8'h08, 8'h00, 4'b0011);
        run_op("shr_81_8",   4'h5, 8'h81, 8'h08, 8'h00, 4'b0011);
        run_op("shl_a5_0",   4'h4, 8'hA5, 8'h00, 8'hA5, 4'b0100);
        run_op("shr_a5_1",   4'h5, 8'hA5, 8'h01, 8'h52, 4'b0001);
        run_op("and_aa_a0",  4'h6, 8'hAA, 8'hA0, 8'hA0, 4'b0100);
        run_op("or_0c_c3",   4'h7, 8'h0C, 8'hC3, 8'hCF, 4'b0100);
        run_op("xor_aa_ff",  4'h8, 8'hAA, 8'hFF, 8'h55, 4'b0000);
        run_op("xnor_aa_0f", 4'h9, 8'hAA, 8'h0F, 8'h5A, 4'b0000);
        run_op("nand_ff_ff", 4'hA, 8'hFF, 8'hFF, 8'h00, 4'b0010);
        run_op("nor_aa_00",  4'hB, 8'hAA, 8'h00, 8'h55, 4'b0000);
        run_op("rol_0c",     4'hC, 8'h0C, 8'h00, 8'h18, 4'b0000);
        run_op("rol_81",     4'hC, 8'h81, 8'h00, 8'h03, 4'b0001);
        run_op("ror_01",     4'hD, 8'h01, 8'h00, 8'h80, 4'b0101);
        run_op("gt_0c_c3",   4'hE, 8'h0C, 8'hC3, 8'h00, 4'b0010);
        run_op("gt_c3_0c",   4'hE, 8'hC3, 8'h0C, 8'h01, 4'b0000);
        run_op("eq_0c_c3",   4'hF, 8'h0C, 8'hC3, 8'h00, 4'b0010);
        run_op("eq_5a_5a",   4'hF, 8'h5A, 8'h5A, 8'h01, 4'b0000);

        // Asynchronous reset between edges, with a nonzero op pending on the inputs.
        run_op("pre_reset",  4'h0, 8'hFF, 8'hFF, 8'hFE, 4'b0101);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("reset_async", {u_if.Out, u_if.Flag}, 12'h000);
        @(posedge clk);
        #1;
        check_eq("reset_hold_edge", {u_if.Out, u_if.Flag}, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("reset_release", {u_if.Out, u_if.Flag}, 12'h000);
        run_op("post_reset_add", 4'h0, 8'h01, 8'h02, 8'h03, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
